// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit sequencer.
// Contents: LU select codes, sequencer FSM state encoding, default operand
// width and the number of LU operations stepped per transaction.
package lu_pkg;

    // Default operand / result width of the logic unit.
    localparam int unsigned LU_WIDTH = 8;

    // Select width and number of operations the LU implements.
    localparam int unsigned LU_SEL_W   = 2;
    localparam int unsigned LU_NUM_OPS = 4;

    // LU select map.
    typedef enum logic [LU_SEL_W-1:0] {
        LU_AND  = 2'b00,
        LU_OR   = 2'b01,
        LU_XOR  = 2'b10,
        LU_NOTA = 2'b11
    } lu_sel_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } lu_state_e;

endpackage : lu_pkg

// File: rtl/lu_op_sequencer.sv
// Sequencer that feeds the combinational logic unit and collects its results.
// One (A,B) pair is accepted per transaction; the LU select is stepped through
// AND, OR, XOR, NOT A on consecutive cycles and the four results, with a zero
// flag per slot, are returned as one bundle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake, in_a/in_b operands
//   lu_a/lu_b/lu_s        operands and select driven to the LU
//   lu_f                  LU result (combinational from lu_a/lu_b/lu_s)
//   out_valid/out_ready   result handshake
//   out_result            slot i (bits WIDTH*(i+1)-1:WIDTH*i) = F for S=i
//   out_zero              bit i set when slot i is zero
//   done_cnt              handed-off transactions, wraps
module lu_op_sequencer
    import lu_pkg::*;
#(
    parameter int unsigned WIDTH = LU_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    output logic [WIDTH-1:0]            lu_a,
    output logic [WIDTH-1:0]            lu_b,
    output logic [LU_SEL_W-1:0]         lu_s,
    input  logic [WIDTH-1:0]            lu_f,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LU_NUM_OPS*WIDTH-1:0] out_result,
    output logic [LU_NUM_OPS-1:0]       out_zero,
    output logic [CNT_W-1:0]            done_cnt
);

    localparam logic [LU_SEL_W-1:0] LAST_SLOT = LU_SEL_W'(LU_NUM_OPS - 1);

    lu_state_e           state;
    logic [LU_SEL_W-1:0] slot_cnt;

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            lu_a       <= '0;
            lu_b       <= '0;
            lu_s       <= LU_AND;
            out_result <= '0;
            out_zero   <= '0;
            done_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Operands are latched here so later input changes cannot
                    // disturb the transaction in flight.
                    if (in_valid && in_ready) begin
                        lu_a     <= in_a;
                        lu_b     <= in_b;
                        slot_cnt <= '0;
                        lu_s     <= LU_AND;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    // lu_s equals slot_cnt this cycle, so lu_f belongs to this slot.
                    out_result[WIDTH*32'(slot_cnt) +: WIDTH] <= lu_f;
                    out_zero[slot_cnt]                       <= (lu_f == '0);
                    slot_cnt                                 <= slot_cnt + LU_SEL_W'(1);
                    if (slot_cnt == LAST_SLOT) begin
                        lu_s      <= LU_AND;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        lu_s <= slot_cnt + LU_SEL_W'(1);
                    end
                end

                DONE: begin
                    // Results stay held until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    slot_cnt  <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    lu_s      <= LU_AND;
                end
            endcase
        end
    end

endmodule : lu_op_sequencer
